muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit implementing the RV32M/RV64M operations for the execute stage of the RISC-V core. It sits beside the ALU. When a M-extension instruction is issued, the control unit raises `start` and holds `PCEn` low while `busy` is high. The result is returned on `result` with a one-cycle `done` pulse, and that value feeds the register-file write-data mux. Unlike the single-cycle ALU, the unit is multi-cycle, width-generic and handshaked.

## Interface
- `XLEN`, default 32: operand/result width; legal values are 32 and 64.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `a`  in  XLEN  rs1 operand; captured with `start`.
- `b`  in  XLEN  rs2 operand; captured with `start`.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  XLEN  last completed result; held until the next completion.

## Operation
- **FSM states:** IDLE, CALC, DONE.
- **IDLE/DONE with `start`=1:**
  - Capture `op`, `a`, `b`.
  - Take absolute values per op signedness: MULH signs both operands, MULHSU signs `a` only, DIV/REM sign both.
  - Record the result sign.
  - Clear the iteration counter ($clog2(XLEN)+1 bits).
  - Go to CALC, or go straight to DONE when a fast path applies.
- **CALC:** one radix-2 step per cycle.
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring subtract on a 2*XLEN remainder/quotient register.
  - After XLEN steps, go to DONE.
- **Entry to DONE:**
  - Register `result` after sign fix-up (two's-complement negate when the recorded sign is negative).
  - Selection: low half for MUL; high half for MULH/MULHSU/MULHU; quotient for DIV/DIVU; remainder for REM/REMU.
  - Remainder sign follows the dividend.
- **DONE:** `done`=1 for exactly one cycle.
  - If `start`=0, go to IDLE.
  - If `start`=1, accept the new request (back-to-back issue).
- **Fast paths (no CALC):**
  - Divide by zero: quotient = all ones; remainder = `a`.
  - Signed overflow (`a` = most negative, `b` = -1): quotient = `a`; remainder = 0.
- `start` while `busy`=1 is ignored; in-flight operands are unaffected.
- `reset_n` low at any point aborts the operation immediately.

## Timing
- **Reset values:**
  - State IDLE; `busy`=0; `done`=0; `result`=0.
  - All internal registers = 0.
- **Iterative latency:**
  - `start` is sampled at edge E.
  - `busy`=1 from after E until after edge E+XLEN.
  - `done` is high in the cycle after edge E+XLEN (XLEN+1 cycles total: 33 for XLEN=32).
- **Fast-path latency:**
  - `busy` stays 0.
  - `done` is high in the cycle after edge E (1 cycle).
- `busy` and `done` are never high together.
- `result` changes only on the edge that raises `done`.

## Configuration
- **`MULDIV_FAST_MUL_EN` defined:**
  - MUL/MULH/MULHSU/MULHU use a single-cycle combinational 2*XLEN product.
  - They complete with fast-path timing (1 cycle, `busy` stays 0).
  - Divide is unchanged.
- **Undefined:** all multiplies are iterative, XLEN+1 cycles.

## Structure
- **`muldiv_pkg`** holds:
  - `muldiv_op_e` (the eight funct3 codes);
  - `muldiv_state_e` (IDLE/CALC/DONE);
  - helper function `is_signed_a`/`is_signed_b`.
- **`op` encoding:** funct3 values, so the decoder can drive it directly.
- **One combinational sub-module, `muldiv_step`:**
  - Takes the accumulator/remainder, the operand and the mode.
  - Returns the next-step value.
  - Instantiated once in `muldiv_unit`.

## Test plan
- MUL, `a`=7, `b`=0xFFFFFFFD (-3) -> `result`=0xFFFFFFEB, `done` 33 cycles after `start`, `busy` high for the 32 cycles before.
- MULHU, `a`=`b`=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each 1 cycle with `busy`=0; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- `start` pulsed with new operands at cycle 10 of a DIV -> ignored, original quotient returned; `start` held through DONE -> second operation accepted with no idle cycle.
- `reset_n` low at cycle 15 of a MUL -> `busy`, `done` and `result` go to 0 immediately; a subsequent MUL 3*4 -> 12.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encodings and operand-signedness helpers for the M-extension unit.
// Pure declarations: no latency, no flow control.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } muldiv_state_e;

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_CALC = ST_CALC;
   localparam logic [1:0] S_DONE = ST_DONE;

   function automatic logic is_signed_a(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_signed_b(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a 2*XLEN register.
// Purely combinational, zero latency; no flow control.
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic              div,
   input  logic [2*XLEN-1:0] acc,
   input  logic [XLEN-1:0]   operand,
   output logic [2*XLEN-1:0] nxt
);

   logic [XLEN:0] sum;
   logic [XLEN:0] trial;

   always_comb begin
      sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
      trial = acc[2*XLEN-1:XLEN-1] - {1'b0, operand};
      nxt   = '0;
      if (div) begin
         // Partial remainder is always below the divisor, so the shifted value fits XLEN+1 bits.
         if (!trial[XLEN])
            nxt = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         else
            nxt = {acc[2*XLEN-2:0], 1'b0};
      end else begin
         // Multiplier sits in the low half and drains out as the product shifts in from the top.
         nxt = {sum, acc[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide: XLEN+1 cycles, or 1 cycle on fast paths; start is ignored while busy.
// Define MULDIV_FAST_MUL_EN for single-cycle combinational multiplies (divide stays iterative).
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int DW    = 2 * XLEN;
   localparam int CNT_W = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]       state;
   logic [2:0]       op_q;
   logic             neg_q;
   logic [CNT_W-1:0] cnt;
   logic [DW-1:0]    acc;
   logic [XLEN-1:0]  operand_q;
   logic [XLEN-1:0]  result_q;
   logic [DW-1:0]    step_nxt;

   logic            div_op;
   logic            a_neg;
   logic            b_neg;
   logic            neg_new;
   logic            dz;
   logic            ovf;
   logic            fast;
   logic [XLEN-1:0] abs_a;
   logic [XLEN-1:0] abs_b;
   logic [XLEN-1:0] fast_res;
   logic            last;

   // Sign fix-up is applied to the full product so MUL's low half and MULH*'s high half are both exact.
   function automatic logic [XLEN-1:0] result_sel(input logic [2:0] f_op, input logic f_neg,
                                                  input logic [DW-1:0] f_acc);
      logic [DW-1:0]   p;
      logic [XLEN-1:0] v;
      p = f_neg ? -f_acc : f_acc;
      v = f_op[1] ? f_acc[DW-1:XLEN] : f_acc[XLEN-1:0];
      if (!f_op[2])
         return (f_op == OP_MUL) ? p[XLEN-1:0] : p[DW-1:XLEN];
      return f_neg ? -v : v;
   endfunction

`ifdef MULDIV_FAST_MUL_EN
   logic [DW-1:0] prod;
   assign prod = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
`endif

   always_comb begin
      div_op   = is_div(op);
      a_neg    = is_signed_a(op) && a[XLEN-1];
      b_neg    = is_signed_b(op) && b[XLEN-1];
      abs_a    = a_neg ? -a : a;
      abs_b    = b_neg ? -b : b;
      // Remainder takes the dividend's sign; everything else takes the product/quotient sign.
      neg_new  = (div_op && op[1]) ? a_neg : (a_neg ^ b_neg);
      dz       = div_op && (b == '0);
      ovf      = ((op == OP_DIV) || (op == OP_REM)) && (a == MOST_NEG) && (b == '1);
      fast     = dz || ovf;
      fast_res = '0;
      if (dz)
         fast_res = op[1] ? a : '1;
      else if (ovf)
         fast_res = op[1] ? '0 : a;
`ifdef MULDIV_FAST_MUL_EN
      else if (!div_op) begin
         fast     = 1'b1;
         fast_res = result_sel(op, neg_new, prod);
      end
`endif
   end

   muldiv_step #(.XLEN(XLEN)) u_step (
      .div     (op_q[2]),
      .acc     (acc),
      .operand (operand_q),
      .nxt     (step_nxt)
   );

   assign last   = (cnt == CNT_W'(XLEN - 1));
   assign busy   = (state == S_CALC);
   assign done   = (state == S_DONE);
   assign result = result_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         op_q      <= '0;
         neg_q     <= 1'b0;
         cnt       <= '0;
         acc       <= '0;
         operand_q <= '0;
         result_q  <= '0;
      end else begin
         case (state)
            S_CALC: begin
               acc <= step_nxt;
               cnt <= cnt + CNT_W'(1);
               if (last) begin
                  result_q <= result_sel(op_q, neg_q, step_nxt);
                  state    <= S_DONE;
               end
            end
            default: begin
               // IDLE and DONE both accept a request, giving back-to-back issue out of DONE.
               if (start) begin
                  op_q      <= op;
                  neg_q     <= neg_new;
                  cnt       <= '0;
                  acc       <= {{XLEN{1'b0}}, abs_a};
                  operand_q <= abs_b;
                  if (fast) begin
                     result_q <= fast_res;
                     state    <= S_DONE;
                  end else begin
                     state <= S_CALC;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vectors for muldiv_unit at XLEN=32 with hand-computed results and latencies.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int vectors = 0;
   int miscompares = 0;
   int overlap = 0;
   int lat;
   int bcnt;

   always #5 clk = ~clk;

   always @(negedge clk) if (busy && done) overlap++;

   muldiv_unit #(.XLEN(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called just after the start edge; lat counts that cycle as 1.
   task automatic wait_done(output int l, output int bc);
      l  = 1;
      bc = 0;
      forever begin
         @(negedge clk);
         if (done || l > 100) break;
         if (busy) bc++;
         l++;
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
      int l, bc;
      issue(o, x, y);
      wait_done(l, bc);
      check({tag, " result"}, 64'(result), 64'(exp));
      check({tag, " latency"}, 64'(l), 64'(exp_lat));
      check({tag, " busy cycles"}, 64'(bc), 64'(exp_lat - 1));
   endtask

   initial begin
      #1;
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset result", 64'(result), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      run("MUL 7*-3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      run("MULHU", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run("MULH", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
      run("MULHSU", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
      run("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      run("REM -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      run("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
      run("REMU 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);

      run("DIVU 5/0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      @(negedge clk);
      check("done pulse width", 64'(done), 64'd0);
      check("result held", 64'(result), 64'hFFFF_FFFF);
      run("REM 5/0", OP_REM, 32'd5, 32'd0, 32'd5, 1);
      run("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run("REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

      // Second start mid-flight must not disturb the running DIV.
      issue(OP_DIV, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      op = OP_DIVU; a = 32'd1; b = 32'd1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; a = 32'd0; b = 32'd0;
      wait_done(lat, bcnt);
      check("ignored start result", 64'(result), 64'd14);

      // start held through DONE issues the next op with no idle cycle.
      @(negedge clk);
      op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk);
      #1;
      wait_done(lat, bcnt);
      check("b2b first result", 64'(result), 64'd14);
      check("b2b first latency", 64'(lat), 64'd33);
      op = OP_REMU;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("b2b no idle busy", 64'(busy), 64'd1);
      check("b2b no idle done", 64'(done), 64'd0);
      wait_done(lat, bcnt);
      check("b2b second result", 64'(result), 64'd2);

      // Reset in the middle of a multiply.
      issue(OP_MUL, 32'h1234_5678, 32'd9);
      repeat (14) @(negedge clk);
      check("busy before abort", 64'(busy), 64'd1);
      reset_n = 1'b0;
      #1;
      check("abort busy", 64'(busy), 64'd0);
      check("abort done", 64'(done), 64'd0);
      check("abort result", 64'(result), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      run("MUL 3*4", OP_MUL, 32'd3, 32'd4, 32'd12, 33);

      check("busy/done overlap", 64'(overlap), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
